// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: fills a 32-bit byte-loadable register memory from an 8-bit
// valid/ready byte stream. It issues one load strobe per byte, can insert idle
// gap cycles between loads, and pulses WORD_DONE once all four lanes are written.
// Optional feature macro: MEMCTL_CLEAR_EN. When it is defined, a CLEAR state
// pulses rst_MEM for one cycle at the start of every word.
module mem_load_ctrl #(
    parameter int unsigned GAP_CYCLES = 1,    // 0..7 idle cycles after each non-final load
    parameter bit          MSB_FIRST  = 1'b0  // 1: fill lanes 3,2,1,0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       START,
    input  logic       ABORT,
    input  logic [7:0] BYTE_IN,
    input  logic       BYTE_VALID,
    output logic       BYTE_READY,
    output logic [7:0] MEM_IN,
    output logic       MEM_LOAD,
    output logic [1:0] MEM_LOAD_VAL,
    output logic       rst_MEM,
    output logic       BUSY,
    output logic       WORD_DONE,
    output logic [2:0] BYTE_CNT
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitByte,
        StLoad,
        StGap,
        StDone
`ifdef MEMCTL_CLEAR_EN
        , StClear
`endif
    } state_e;

    localparam logic [1:0] FirstLane = MSB_FIRST ? 2'd3 : 2'd0;
    // The gap counter counts down to zero, so load one less than the gap length.
    localparam logic [2:0] GapLoad   = 3'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] mem_in_q, mem_in_d;
    logic [1:0] load_val_q, load_val_d;   // lane shown to MEM; holds outside LOAD
    logic [1:0] lane_q, lane_d;           // lane the next accepted byte goes to
    logic [2:0] byte_cnt_q, byte_cnt_d;
    logic [2:0] gap_cnt_q, gap_cnt_d;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ABORT overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (ABORT) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (START) begin
`ifdef MEMCTL_CLEAR_EN
                        state_d = StClear;
`else
                        state_d = StWaitByte;
`endif
                    end
                end
`ifdef MEMCTL_CLEAR_EN
                StClear:    state_d = StWaitByte;
`endif
                StWaitByte: begin
                    if (BYTE_VALID) begin
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    if (byte_cnt_q == 3'd3) begin
                        state_d = StDone;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                    end else begin
                        state_d = StWaitByte;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == 3'd0) begin
                        state_d = StWaitByte;
                    end
                end
                StDone:     state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        BYTE_READY = 1'b0;
        MEM_LOAD   = 1'b0;
        rst_MEM    = 1'b0;
        WORD_DONE  = 1'b0;
        BUSY       = (state_q != StIdle);
        unique case (state_q)
            StWaitByte: BYTE_READY = 1'b1;
            StLoad:     MEM_LOAD   = 1'b1;
            StDone:     WORD_DONE  = 1'b1;
`ifdef MEMCTL_CLEAR_EN
            StClear:    rst_MEM    = 1'b1;
`endif
            default: ;
        endcase
    end

    // Datapath next-state: byte latch, lane tracking, lane count and gap timer.
    // ABORT blocks a START or a handshake in the same cycle; a LOAD already on
    // the bus still completes its bookkeeping because MEM captures it anyway.
    always_comb begin
        mem_in_d   = mem_in_q;
        load_val_d = load_val_q;
        lane_d     = lane_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (START && !ABORT) begin
                    lane_d     = FirstLane;
                    byte_cnt_d = 3'd0;
                end
            end
            StWaitByte: begin
                if (BYTE_VALID && !ABORT) begin
                    mem_in_d   = BYTE_IN;
                    load_val_d = lane_q;
                end
            end
            StLoad: begin
                byte_cnt_d = byte_cnt_q + 3'd1;
                lane_d     = MSB_FIRST ? (lane_q - 2'd1) : (lane_q + 2'd1);
                gap_cnt_d  = GapLoad;
            end
            StGap: begin
                if (gap_cnt_q != 3'd0) begin
                    gap_cnt_d = gap_cnt_q - 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_in_q   <= 8'h00;
            load_val_q <= 2'b00;
            lane_q     <= FirstLane;
            byte_cnt_q <= 3'd0;
            gap_cnt_q  <= 3'd0;
        end else begin
            mem_in_q   <= mem_in_d;
            load_val_q <= load_val_d;
            lane_q     <= lane_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign MEM_IN       = mem_in_q;
    assign MEM_LOAD_VAL = load_val_q;
    assign BYTE_CNT     = byte_cnt_q;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed bench for mem_load_ctrl. Three instances share START/ABORT/BYTE_VALID/rst_n:
// a = defaults, b = MSB_FIRST, c = GAP_CYCLES 0. Each has its own byte source and
// a behavioural model of MEM.
module tb_mem_load_ctrl;

`ifdef MEMCTL_CLEAR_EN
    localparam int  O   = 0;  // cycle offset relative to the CLEAR-enabled timing
    localparam bit  CLR = 1'b1;
`else
    localparam int  O   = 1;
    localparam bit  CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, start, abort, valid, src_rst;

    logic [7:0] byte_in_a, byte_in_b, byte_in_c;
    logic       ready_a, ready_b, ready_c;
    logic [7:0] mem_in_a, mem_in_b, mem_in_c;
    logic       load_a, load_b, load_c;
    logic [1:0] lv_a, lv_b, lv_c;
    logic       rmem_a, rmem_b, rmem_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_load_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .START(start), .ABORT(abort), .BYTE_IN(byte_in_a),
        .BYTE_VALID(valid), .BYTE_READY(ready_a), .MEM_IN(mem_in_a), .MEM_LOAD(load_a),
        .MEM_LOAD_VAL(lv_a), .rst_MEM(rmem_a), .BUSY(busy_a), .WORD_DONE(done_a),
        .BYTE_CNT(cnt_a)
    );
    mem_load_ctrl #(.GAP_CYCLES(1), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .START(start), .ABORT(abort), .BYTE_IN(byte_in_b),
        .BYTE_VALID(valid), .BYTE_READY(ready_b), .MEM_IN(mem_in_b), .MEM_LOAD(load_b),
        .MEM_LOAD_VAL(lv_b), .rst_MEM(rmem_b), .BUSY(busy_b), .WORD_DONE(done_b),
        .BYTE_CNT(cnt_b)
    );
    mem_load_ctrl #(.GAP_CYCLES(0), .MSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .START(start), .ABORT(abort), .BYTE_IN(byte_in_c),
        .BYTE_VALID(valid), .BYTE_READY(ready_c), .MEM_IN(mem_in_c), .MEM_LOAD(load_c),
        .MEM_LOAD_VAL(lv_c), .rst_MEM(rmem_c), .BUSY(busy_c), .WORD_DONE(done_c),
        .BYTE_CNT(cnt_c)
    );

    // Byte sources: advance on each accepted handshake.
    logic [7:0] src_a [4];
    logic [7:0] src_b [4];
    logic [2:0] idx_a, idx_b, idx_c;

    always @(posedge clk) begin
        if (src_rst) begin
            idx_a <= 3'd0; idx_b <= 3'd0; idx_c <= 3'd0;
        end else begin
            if (valid && ready_a && !abort) idx_a <= idx_a + 3'd1;
            if (valid && ready_b && !abort) idx_b <= idx_b + 3'd1;
            if (valid && ready_c && !abort) idx_c <= idx_c + 3'd1;
        end
    end

    assign byte_in_a = (idx_a < 3'd4) ? src_a[idx_a[1:0]] : 8'h00;
    assign byte_in_b = (idx_b < 3'd4) ? src_b[idx_b[1:0]] : 8'h00;
    assign byte_in_c = (idx_c < 3'd4) ? src_a[idx_c[1:0]] : 8'h00;

    // MEM models: clear on rst_MEM, byte-lane load on MEM_LOAD.
    logic [31:0] mem_a = 32'h0, mem_b = 32'h0, mem_c = 32'h0;
    always @(posedge clk) begin
        if (rmem_a) mem_a <= 32'h0;
        else if (load_a) mem_a[{lv_a, 3'b000} +: 8] <= mem_in_a;
        if (rmem_b) mem_b <= 32'h0;
        else if (load_b) mem_b[{lv_b, 3'b000} +: 8] <= mem_in_b;
        if (rmem_c) mem_c <= 32'h0;
        else if (load_c) mem_c[{lv_c, 3'b000} +: 8] <= mem_in_c;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; src_rst = 1'b1; abort = 1'b0; start = 1'b0; valid = 1'b0;
        tick();
        rst_n = 1'b1; src_rst = 1'b0;
    endtask

    // Pulse START across one edge; afterwards the bench is in cycle 1.
    task automatic start_word();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int n;
        src_a[0] = 8'hAA; src_a[1] = 8'hFF; src_a[2] = 8'hCC; src_a[3] = 8'hDD;
        src_b[0] = 8'h11; src_b[1] = 8'h22; src_b[2] = 8'h33; src_b[3] = 8'h44;
        rst_n = 1'b0; src_rst = 1'b1; abort = 1'b0; start = 1'b0; valid = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_mem_in", mem_in_a, 8'h00);
        chk("rst_load_val", lv_a, 2'b00);
        chk("rst_load_val_msb", lv_b, 2'b00);
        chk("rst_byte_cnt", cnt_a, 3'd0);
        chk("rst_mem_load", load_a, 1'b0);
        chk("rst_rst_mem", rmem_a, 1'b0);
        chk("rst_ready", ready_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        rst_n = 1'b1; src_rst = 1'b0;

        // Full word on all three variants, BYTE_VALID held high
        valid = 1'b1;
        start_word();
        for (int c = 1; c <= 14 - O; c++) begin
            k = c + O;
            chk($sformatf("a_rst_mem_c%0d", c), rmem_a, (k == 1));
            chk($sformatf("a_load_c%0d", c), load_a, (k % 3 == 0 && k <= 12));
            if (k % 3 == 0 && k <= 12) begin
                chk($sformatf("a_lane_c%0d", c), lv_a, k / 3 - 1);
                chk($sformatf("b_lane_c%0d", c), lv_b, 3 - (k / 3 - 1));
            end
            chk($sformatf("a_done_c%0d", c), done_a, (k == 13));
            chk($sformatf("a_busy_c%0d", c), busy_a, (k <= 13));
            chk($sformatf("b_load_c%0d", c), load_b, (k % 3 == 0 && k <= 12));
            chk($sformatf("b_done_c%0d", c), done_b, (k == 13));
            chk($sformatf("c_load_c%0d", c), load_c, (k % 2 == 1 && k >= 3 && k <= 9));
            if (k % 2 == 1 && k >= 3 && k <= 9)
                chk($sformatf("c_lane_c%0d", c), lv_c, (k - 3) / 2);
            chk($sformatf("c_done_c%0d", c), done_c, (k == 10));
            chk($sformatf("c_busy_c%0d", c), busy_c, (k <= 10));
            tick();
        end
        chk("a_mem_out", mem_a, 32'hDDCCFFAA);
        chk("b_mem_out", mem_b, 32'h11223344);
        chk("c_mem_out", mem_c, 32'hDDCCFFAA);
        chk("a_cnt_final", cnt_a, 3'd4);
        chk("b_cnt_final", cnt_b, 3'd4);
        chk("c_cnt_final", cnt_c, 3'd4);
        chk("b_lane_hold", lv_b, 2'd0);

        // Stalled stream before byte 2
        do_reset();
        valid = 1'b1;
        start_word();
        while (cyc < 3 - O) tick();
        chk("stall_load1", load_a, 1'b1);
        valid = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("stall_ready_%0d", s), ready_a, 1'b1);
            chk($sformatf("stall_noload_%0d", s), load_a, 1'b0);
            chk($sformatf("stall_mem_in_%0d", s), mem_in_a, 8'hAA);
            tick();
        end
        valid = 1'b1;
        chk("stall_ready_last", ready_a, 1'b1);
        tick();
        chk("stall_load2", load_a, 1'b1);
        chk("stall_lane2", lv_a, 2'd1);
        chk("stall_byte2", mem_in_a, 8'hFF);
        n = 0;
        while (!done_a && n < 20) begin tick(); n++; end
        chk("stall_done_seen", done_a, 1'b1);
        tick();
        chk("stall_mem_out", mem_a, 32'hDDCCFFAA);

        // ABORT in the cycle after the second LOAD
        do_reset();
        valid = 1'b1;
        start_word();
        while (cyc < 6 - O) tick();
        chk("abort_load2", load_a, 1'b1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", busy_a, 1'b0);
        chk("abort_done", done_a, 1'b0);
        chk("abort_cnt", cnt_a, 3'd2);
        chk("abort_ready", ready_a, 1'b0);
        chk("abort_load", load_a, 1'b0);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("abort_nodone_%0d", s), done_a, 1'b0);
            tick();
        end
        chk("abort_mem_out", mem_a, CLR ? 32'h0000FFAA : 32'hDDCCFFAA);
        src_rst = 1'b1;
        tick();
        src_rst = 1'b0;
        start_word();
        chk("restart_cnt", cnt_a, 3'd0);
        chk("restart_rst_mem", rmem_a, CLR);
        while (cyc < 3 - O) tick();
        chk("restart_load", load_a, 1'b1);
        chk("restart_lane", lv_a, 2'd0);
        chk("restart_byte", mem_in_a, 8'hAA);
        chk("restart_mem", mem_a, CLR ? 32'h0 : 32'hDDCCFFAA);

        // START while in WAIT_BYTE is ignored; reset mid-word
        do_reset();
        start_word();
        while (cyc < 2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_rst_mem", rmem_a, 1'b0);
        chk("ign_ready", ready_a, 1'b1);
        chk("ign_busy", busy_a, 1'b1);
        chk("ign_load", load_a, 1'b0);
        valid = 1'b1;
        tick();
        chk("ign_load_after", load_a, 1'b1);
        chk("ign_lane", lv_a, 2'd0);
        chk("ign_byte", mem_in_a, 8'hAA);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        valid = 1'b0;
        chk("mid_rst_mem_in", mem_in_a, 8'h00);
        chk("mid_rst_lane", lv_a, 2'b00);
        chk("mid_rst_cnt", cnt_a, 3'd0);
        chk("mid_rst_load", load_a, 1'b0);
        chk("mid_rst_rst_mem", rmem_a, 1'b0);
        chk("mid_rst_ready", ready_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_done", done_a, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
